// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, parity type and line-level constants.
// UART_TX_PARITY_EN adds the PARITY state to the TX state encoding.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data capture register and bit counter for the UART transmitter.
// Presents the data bit the line will carry after the next edge.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // Counter saturates at the last bit; the FSM leaves DATA there.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance && !ser_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign ser_bit = data_q[cnt_d];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                data_q <= p_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; one bit per clk.
// Define UART_TX_PARITY_EN to compile in the per-frame parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    uart_tx_state_t state_q, state_d;
    logic load, clear, advance;
    logic ser_bit, ser_done;
    logic tx_d, busy_d;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .clear    (clear),
        .advance  (advance),
        .p_data   (P_DATA),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_bit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (load) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
    end
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Outputs are registered from the next state so TX_OUT/Busy come straight from flops.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                clear   = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end else begin
                    advance = 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            STOP: begin
                if (Data_Valid) begin
                    load    = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = ser_bit;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_q;
`endif
            default: tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            TX_OUT  <= LINE_IDLE;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            Busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx (8-bit frames); parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam logic HAS_PAR = 1'b1;
`else
    localparam logic HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int failures = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    // Expected line level in frame cycle i (pe is the effective parity enable).
    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && pe) return (^d) ^ pt;
        return 1'b1;
    endfunction

    // Presents a request for exactly one rising edge, then scrambles the inputs.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(posedge clk); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            Data_Valid = i[0]; P_DATA = 8'h5A ^ 8'(i); PAR_EN = i[1]; PAR_TYP = i[0];
            @(negedge clk);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0)
                $display("FAIL reset_hold cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) failures++;
        end
        Data_Valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic pe, input logic pt);
        logic pe_eff;
        int   len;
        pe_eff = pe & HAS_PAR;
        len    = pe_eff ? 11 : 10;
        send(d, pe, pt);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== exp_bit(d, pe_eff, pt, i) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL %s bit=%0d tx=%b busy=%b expected tx=%b busy=1",
                         name, i, TX_OUT, Busy, exp_bit(d, pe_eff, pt, i));
            end
        end
        @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_end tx=%b busy=%b expected tx=1 busy=0", name, TX_OUT, Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic pe_eff;
        int   len;
        pe_eff = HAS_PAR;
        len    = pe_eff ? 11 : 10;
        send(8'h80, 1'b1, 1'b1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== exp_bit(8'h80, pe_eff, 1'b1, i) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_first bit=%0d tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_bit(8'h80, pe_eff, 1'b1, i));
            end
        end
        // Request lands on the edge that ends the stop bit.
        P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0; P_DATA = 8'hFE;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== exp_bit(8'h01, pe_eff, 1'b1, i) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_second bit=%0d tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_bit(8'h01, pe_eff, 1'b1, i));
            end
        end
        @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    task automatic test_ignore_valid();
        send(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== exp_bit(8'h00, 1'b0, 1'b0, i) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL ignore bit=%0d tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_bit(8'h00, 1'b0, 1'b0, i));
            end
            if (i == 3) begin
                P_DATA = 8'hFF; Data_Valid = 1'b1;
            end else if (i == 4) begin
                Data_Valid = 1'b0;
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL ignore_idle cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_reset_midframe();
        send(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== exp_bit(8'h3C, 1'b0, 1'b0, i) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL midrst_pre bit=%0d tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_bit(8'h3C, 1'b0, 1'b0, i));
            end
        end
        // Bit 4 (data bit 3 = 1) is on the line; reset must force idle without a clock edge.
        #1 rst = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
        test_frame("midrst_clean", 8'h5A, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame("a5_nopar", 8'hA5, 1'b0, 1'b0);
        test_frame("a5_even", 8'hA5, 1'b1, 1'b0);
        test_frame("a5_odd", 8'hA5, 1'b1, 1'b1);
        test_frame("c3_odd", 8'hC3, 1'b1, 1'b1);
        test_frame("07_even", 8'h07, 1'b1, 1'b0);
        test_back_to_back();
        test_ignore_valid();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the UART block: the transmit-side counterpart of the UART receive path. Accepts a parallel byte with a one-cycle valid strobe, then serializes a standard frame on `TX_OUT`: start bit, data LSB first, optional parity, stop bit. Runs on the TX bit clock, one bit per `clk` cycle. Any baud division happens upstream in the clock divider. Signals `Busy` while a frame is in flight.

## Interface

- `DATA_WIDTH`, default 8: number of data bits per frame.
- `clk`  input  1  TX bit clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `P_DATA`  input  DATA_WIDTH  parallel data to transmit.
- `Data_Valid`  input  1  one-cycle request; `P_DATA`, `PAR_EN` and `PAR_TYP` are valid while it is high.
- `PAR_EN`  input  1  1 = include a parity bit in this frame.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `TX_OUT`  output  1  serial line, registered; idles high.
- `Busy`  output  1  high from the accept edge through the last stop-bit cycle, registered.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1, `Busy`=0.
  - If `Data_Valid`=1 at a clock edge, capture `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers, compute parity, then go to START.
- START:
  - `TX_OUT`=0 for one cycle, then go to DATA.
- DATA:
  - Bit counter runs 0..DATA_WIDTH-1. `TX_OUT` = captured data[counter] (LSB first).
  - After bit DATA_WIDTH-1, go to PARITY if the captured `PAR_EN`=1, else go to STOP.
- PARITY:
  - `TX_OUT` = ^data for even parity, ~^data for odd parity. One cycle, then go to STOP.
- STOP:
  - `TX_OUT`=1 for one cycle.
  - If `Data_Valid`=1 on that edge, capture the new data and go to START (back-to-back frame, no idle gap, `Busy` stays 1).
  - Otherwise go to IDLE.
- `Data_Valid` in START, DATA or PARITY is ignored. No queuing and no error flag; the upstream block must respect `Busy`.
- Input changes after the accept edge do not affect the frame in flight. Parity config is per-frame.
- Bit counter width is $clog2(DATA_WIDTH). It is cleared on entry to DATA and does not wrap past DATA_WIDTH-1.
- Reset, including mid-frame: immediately go to IDLE, `TX_OUT`=1, `Busy`=0, counter=0, captured data=0. A partial frame is abandoned, and the line returning high is the required behaviour.

## Timing

- Accept at edge k: start bit drives `TX_OUT` in cycle k..k+1. `Busy` goes high at edge k.
- Data bit i occupies cycle k+1+i.
- Parity, if present, occupies cycle k+1+DATA_WIDTH.
- Stop occupies the final cycle.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10 or 11 cycles at 8 bits).
- `Busy` falls at the edge ending the stop bit, unless a back-to-back accept happens on that edge.
- Minimum frame spacing is 0 idle cycles.
- Both outputs come directly from flops, with no combinational path from inputs.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - PARITY state, the parity generator and the `PAR_EN`/`PAR_TYP` capture registers are compiled in. Behaviour is as above.
- `UART_TX_PARITY_EN` undefined:
  - Parity logic and the PARITY state are removed. `PAR_EN` and `PAR_TYP` are ports but ignored.
  - Every frame is DATA_WIDTH+2 cycles.

## Structure

- Shared package `uart_pkg`:
  - FSM state enum (`uart_tx_state_t`).
  - Parity type constants `PAR_EVEN`=0 and `PAR_ODD`=1.
  - Line levels `LINE_IDLE`=1 and `START_BIT`=0.
- One sub-module `uart_tx_serializer`: captured data register, bit counter, and a `ser_done` flag. The top holds the FSM, parity bit and output mux.

## Test plan

- Reset held low with inputs toggling -> `TX_OUT`=1 and `Busy`=0 throughout. After release with no `Data_Valid`, the line stays idle.
- `P_DATA`=0xA5, `PAR_EN`=0 -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. `Busy` is high for exactly those 10 cycles.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 -> parity bit 0, 11-cycle frame. Same data with `PAR_TYP`=1 -> parity bit 1.
- `P_DATA`=0x80, odd parity, then 0x01 on the stop-cycle edge -> second start bit directly follows the stop bit, and `Busy` never drops.
- `Data_Valid` pulsed with 0xFF during DATA of a 0x00 frame -> 0x00 frame completes unchanged, and 0xFF is never sent.
- `rst` asserted in the 4th data bit -> `TX_OUT`=1 and `Busy`=0 asynchronously. The next request sends a full clean frame.
